// File: rtl/ovl_fire_pkg.sv
// ovl_fire_pkg: shared FSM encoding, fire bit positions and sizing helper for the fire collector
package ovl_fire_pkg;
  typedef enum logic [1:0] {IDLE, ALERT, HOLD} state_e;
  localparam int FIRE_2STATE = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER = 2;
  localparam int FIRE_W = 3;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ovl_fire_popcount.sv
// ovl_fire_popcount: population count of one fire bit across all checkers
module ovl_fire_popcount #(
  parameter int N = 4,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) count_o = count_o + W'(bits_i[i]);
  end
endmodule

// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: counts OVL checker fires, records the first failing checker and raises irq
module ovl_fire_collector
  import ovl_fire_pkg::*;
#(
  parameter int num_checkers = 4,
  parameter int count_width = 16,
  parameter bit irq_on_xcheck = 1'b1,
  localparam int ID_W = id_width(num_checkers)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [FIRE_W*num_checkers-1:0] fire_in,
  input  logic                           clear,
  input  logic                           ack,
  output logic [count_width-1:0]         error_count,
  output logic [count_width-1:0]         xcheck_count,
  output logic [count_width-1:0]         cover_count,
  output logic [ID_W-1:0]                first_id,
  output logic                           first_valid,
  output logic                           irq
);
  localparam int PW = $clog2(num_checkers + 1);
  localparam int SW = (count_width > PW ? count_width : PW) + 1;
  logic [num_checkers-1:0] two_v, xck_v, cov_v, err_v;
  logic [PW-1:0] pc [FIRE_W];
  logic [count_width-1:0] cnt_q [FIRE_W];
  logic [count_width-1:0] cnt_d [FIRE_W];
  logic [ID_W-1:0] id_q, id_d, low_id;
  logic valid_q, valid_d, ev, irq_q;
  state_e state_q;
  function automatic logic [count_width-1:0] sat_add(input logic [count_width-1:0] a, input logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return |(s >> count_width) ? '1 : s[count_width-1:0];
  endfunction
  // Only a definite 1 counts; X/Z and disabled cycles contribute nothing.
  always_comb begin
    for (int i = 0; i < num_checkers; i++) begin
      two_v[i] = enable && (fire_in[FIRE_W*i+FIRE_2STATE] === 1'b1);
      xck_v[i] = enable && (fire_in[FIRE_W*i+FIRE_XCHECK] === 1'b1);
      cov_v[i] = enable && (fire_in[FIRE_W*i+FIRE_COVER] === 1'b1);
    end
  end
  assign err_v = two_v | (irq_on_xcheck ? xck_v : '0);
  assign ev = |err_v;
  always_comb begin
    low_id = '0;
    for (int i = num_checkers - 1; i >= 0; i--) if (err_v[i]) low_id = ID_W'(i);
  end
  ovl_fire_popcount #(.N(num_checkers)) u_pc_two (.bits_i(two_v), .count_o(pc[FIRE_2STATE]));
  ovl_fire_popcount #(.N(num_checkers)) u_pc_xck (.bits_i(xck_v), .count_o(pc[FIRE_XCHECK]));
  ovl_fire_popcount #(.N(num_checkers)) u_pc_cov (.bits_i(cov_v), .count_o(pc[FIRE_COVER]));
  always_comb begin
    for (int k = 0; k < FIRE_W; k++) cnt_d[k] = clear ? '0 : sat_add(cnt_q[k], pc[k]);
    valid_d = !clear && (valid_q || ev);
    id_d = clear ? '0 : (!valid_q && ev) ? low_id : id_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FIRE_W; k++) cnt_q[k] <= '0;
      valid_q <= 1'b0;
      id_q <= '0;
    end else begin
      for (int k = 0; k < FIRE_W; k++) cnt_q[k] <= cnt_d[k];
      valid_q <= valid_d;
      id_q <= id_d;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      irq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ev) begin state_q <= ALERT; irq_q <= 1'b1; end
        ALERT: if (ack && !ev) begin state_q <= HOLD; irq_q <= 1'b0; end
        HOLD: if (ev) begin state_q <= ALERT; irq_q <= 1'b1; end
        default: begin state_q <= IDLE; irq_q <= 1'b0; end
      endcase
    end
  end
  assign error_count = cnt_q[FIRE_2STATE];
  assign xcheck_count = cnt_q[FIRE_XCHECK];
  assign cover_count = cnt_q[FIRE_COVER];
  assign first_id = id_q;
  assign first_valid = valid_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_ovl_fire_collector.sv
// tb_ovl_fire_collector: directed and random checks of two collector configurations against a behavioural model
module tb_ovl_fire_collector;
  localparam int N = 4;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0, ack = 1'b0;
  logic [3*N-1:0] fire_in = '0;
  logic [3:0] ea, xa, ca;
  logic [15:0] eb, xb, cb;
  logic [1:0] fa, fb;
  logic va, vb, ia, ib;
  int checks = 0, failures = 0;
  int m_cnt [2][3];
  int m_first [2];
  bit m_valid [2], m_irq [2];
  int cmax [2] = '{15, 65535};
  bit xirq [2] = '{1'b1, 1'b0};

  ovl_fire_collector #(.num_checkers(N), .count_width(4), .irq_on_xcheck(1'b1)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in), .clear(clear), .ack(ack),
    .error_count(ea), .xcheck_count(xa), .cover_count(ca), .first_id(fa), .first_valid(va), .irq(ia));
  ovl_fire_collector #(.num_checkers(N), .count_width(16), .irq_on_xcheck(1'b0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in), .clear(clear), .ack(ack),
    .error_count(eb), .xcheck_count(xb), .cover_count(cb), .first_id(fb), .first_valid(vb), .irq(ib));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) m_cnt[d][k] = 0;
      m_first[d] = 0;
      m_valid[d] = 1'b0;
      m_irq[d] = 1'b0;
    end
  endfunction

  // Irq is simply "an error is pending software attention": set by any error, dropped by ack.
  function automatic void m_step();
    if (!reset || clear) begin
      m_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int low = -1;
      if (enable) begin
        for (int k = 0; k < 3; k++) begin
          int pop = 0;
          for (int i = 0; i < N; i++) pop += int'(fire_in[3*i+k]);
          m_cnt[d][k] = (m_cnt[d][k] + pop > cmax[d]) ? cmax[d] : m_cnt[d][k] + pop;
        end
        for (int i = N - 1; i >= 0; i--)
          if (fire_in[3*i] || (xirq[d] && fire_in[3*i+1])) low = i;
      end
      if (low >= 0 && !m_valid[d]) begin
        m_first[d] = low;
        m_valid[d] = 1'b1;
      end
      m_irq[d] = (low >= 0) ? 1'b1 : (ack ? 1'b0 : m_irq[d]);
    end
  endfunction

  task automatic check_all();
    chk("a_error_count", int'(ea), m_cnt[0][0]);
    chk("a_xcheck_count", int'(xa), m_cnt[0][1]);
    chk("a_cover_count", int'(ca), m_cnt[0][2]);
    chk("a_first_id", int'(fa), m_first[0]);
    chk("a_first_valid", int'(va), int'(m_valid[0]));
    chk("a_irq", int'(ia), int'(m_irq[0]));
    chk("b_error_count", int'(eb), m_cnt[1][0]);
    chk("b_xcheck_count", int'(xb), m_cnt[1][1]);
    chk("b_cover_count", int'(cb), m_cnt[1][2]);
    chk("b_first_id", int'(fb), m_first[1]);
    chk("b_first_valid", int'(vb), int'(m_valid[1]));
    chk("b_irq", int'(ib), int'(m_irq[1]));
  endtask

  task automatic cycle();
    @(posedge clock);
    m_step();
    #1 check_all();
  endtask

  initial begin
    m_reset();
    #12 check_all();
    chk("reset_irq_lit", int'(ia), 0);
    #5 reset = 1'b1;
    enable = 1'b1;
    fire_in[3] = 1'b1;
    fire_in[9] = 1'b1;
    cycle();
    chk("two_fires_err", int'(eb), 2);
    chk("two_fires_id", int'(fa), 1);
    chk("two_fires_valid", int'(vb), 1);
    chk("two_fires_irq", int'(ia), 1);
    fire_in = '0;
    ack = 1'b1;
    cycle();
    chk("ack_to_hold_irq", int'(ia), 0);
    ack = 1'b0;
    fire_in[6] = 1'b1;
    cycle();
    chk("hold_realert_irq", int'(ia), 1);
    chk("hold_first_id_kept", int'(fa), 1);
    fire_in = '0;
    fire_in[0] = 1'b1;
    ack = 1'b1;
    cycle();
    chk("ack_with_err_irq", int'(ib), 1);
    chk("ack_with_err_count", int'(eb), 4);
    ack = 1'b0;
    clear = 1'b1;
    fire_in = '0;
    fire_in[2] = 1'b1;
    cycle();
    chk("clear_cover", int'(ca), 0);
    chk("clear_err", int'(ea), 0);
    chk("clear_valid", int'(va), 0);
    chk("clear_irq", int'(ia), 0);
    clear = 1'b0;
    fire_in = '0;
    fire_in[0] = 1'b1;
    for (int c = 0; c < 20; c++) cycle();
    chk("sat_a_err", int'(ea), 15);
    chk("nosat_b_err", int'(eb), 20);
    enable = 1'b0;
    ack = 1'b1;
    cycle();
    chk("disabled_frozen", int'(eb), 20);
    chk("disabled_ack_irq", int'(ib), 0);
    ack = 1'b0;
    enable = 1'b1;
    clear = 1'b1;
    fire_in = '0;
    cycle();
    clear = 1'b0;
    fire_in[10] = 1'b1;
    cycle();
    chk("xck_b_count", int'(xb), 1);
    chk("xck_b_irq", int'(ib), 0);
    chk("xck_b_valid", int'(vb), 0);
    chk("xck_a_irq", int'(ia), 1);
    chk("xck_a_id", int'(fa), 3);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_irq", int'(ia), 0);
    chk("async_rst_xck", int'(xa), 0);
    chk("async_rst_valid", int'(va), 0);
    m_reset();
    check_all();
    #1 reset = 1'b1;
    fire_in = '0;
    for (int c = 0; c < 3000; c++) begin
      fire_in = 12'($urandom & $urandom & $urandom);
      enable = $urandom_range(0, 7) != 0;
      clear = $urandom_range(0, 63) == 0;
      ack = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        m_reset();
        #1 check_all();
        reset = 1'b1;
      end
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ovl_fire_collector.md
OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

Interface
REQ-001 Parameter: num_checkers, 4, number of OVL checkers whose fire buses are collected (1..32).
REQ-002 Parameter: count_width, 16, width of each event counter.
REQ-003 Parameter: irq_on_xcheck, 1, when 1 an X-check fire also raises irq; when 0 only 2-state fires do.
REQ-004 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  collection enable; when 0, fire_in is ignored.
REQ-007 Port: fire_in  input  3*num_checkers  concatenated checker fire buses; checker i occupies [3i+2:3i], bit0 = 2-state, bit1 = xcheck, bit2 = cover.
REQ-008 Port: clear  input  1  synchronous clear of counters, first-fail record and state.
REQ-009 Port: ack  input  1  software acknowledge of irq.
REQ-010 Port: error_count  output  count_width  total 2-state fires, saturating.
REQ-011 Port: xcheck_count  output  count_width  total xcheck fires, saturating.
REQ-012 Port: cover_count  output  count_width  total cover fires, saturating.
REQ-013 Port: first_id  output  ID_W  index of the first checker to fire 2-state or xcheck; ID_W = max(1, clog2(num_checkers)).
REQ-014 Port: first_valid  output  1  first_id holds a recorded index.
REQ-015 Port: irq  output  1  alert to software, registered.

Function
REQ-016 fire_in SHALL be sampled on each rising edge with enable=1; all outputs SHALL reflect that sample exactly one cycle later (registered, no combinational input-to-output paths).
REQ-017 Each counter SHALL add the per-cycle population count of its fire bit across all checkers (adder width clog2(num_checkers+1)) and SHALL saturate at all-ones, never wrapping.
REQ-018 An error event SHALL be any sampled 2-state bit set, or any xcheck bit set when irq_on_xcheck=1.
REQ-019 first_id SHALL latch the lowest-index checker with an error event in the first error cycle while first_valid=0; first_valid SHALL then stay 1 and first_id SHALL hold until clear or reset.
REQ-020 FSM states SHALL be IDLE, ALERT and HOLD; irq=1 in ALERT only.
REQ-021 IDLE -> ALERT on error event; ALERT -> HOLD on ack with no error event in the same cycle; ALERT stays ALERT on ack with a simultaneous error event; HOLD -> ALERT on a new error event; ack in IDLE or HOLD SHALL be ignored.
REQ-022 clear SHALL zero all counters, first_valid and first_id, and force IDLE next cycle from any state; clear wins over a same-cycle fire, which SHALL NOT be counted.
REQ-023 enable=0 SHALL freeze counters, first-fail record and FSM state; clear and ack SHALL still act.
REQ-024 X or Z on fire_in bits SHALL count as 0 for counters and events.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, irq=0, first_valid=0, first_id=0 and all counters=0.
REQ-026 Reset deassertion SHALL take effect at the next rising clock edge; mid-operation reset SHALL discard all recorded events.

Structure
REQ-027 A shared package ovl_fire_pkg SHALL hold the FSM state encoding and the fire bit-position constants (2-state=0, xcheck=1, cover=2), reused by all checkers.
REQ-028 One sub-module, ovl_fire_popcount, SHALL compute the per-bit population count across checkers and be instantiated three times.

Verification
REQ-029 num_checkers=4; fire_in 2-state bits of checkers 1 and 3 set for one cycle -> next cycle error_count=2, first_id=1, first_valid=1, irq=1.
REQ-030 count_width=4; 2-state fire from checker 0 held for 20 cycles -> error_count stops at 15 and stays 15.
REQ-031 In ALERT, ack alone -> irq=0 next cycle (HOLD); then checker 2 2-state fire -> irq=1, first_id stays at the original value.
REQ-032 In ALERT, ack with a simultaneous checker 0 error -> irq stays 1; error_count increments by 1.
REQ-033 clear with a simultaneous checker 0 cover fire -> all counters 0, cover_count stays 0, first_valid=0, irq=0 next cycle.
REQ-034 irq_on_xcheck=0 with a checker 3 xcheck fire -> xcheck_count=1, irq=0, first_valid=0; reset=0 mid-ALERT -> all outputs 0 immediately, without waiting for a clock edge.
